// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared next-PC select encodings, NOP word and fetch state enum.
package rv32i_pkg;

   typedef enum logic [1:0] {
      PCSEL_PLUS4  = 2'b00,
      PCSEL_BRANCH = 2'b01,
      PCSEL_JAL    = 2'b10,
      PCSEL_JALR   = 2'b11
   } pc_sel_e;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD,
      S_FAULT
   } fetch_state_e;

endpackage

// File: rtl/next_pc_gen.sv
// next_pc_gen: combinational next-PC selection with misalignment detect.
module next_pc_gen
   import rv32i_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [1:0]  pc_sel_i,
   input  logic [31:0] ext_imm_i,
   input  logic [31:0] rdout1_i,
   output logic [31:0] next_pc_o,
   output logic        misaligned_o
);

   always_comb begin
      next_pc_o = pc_sel_i == PCSEL_PLUS4 ? pc_i + 32'd4 :
                  pc_sel_i == PCSEL_JALR  ? (rdout1_i + ext_imm_i) & ~32'd1 :
                                            pc_i + ext_imm_i;
      misaligned_o = next_pc_o[1];
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage; owns the PC, fetches over req/ack and holds
// the instruction for decode until the core retires it.
module fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned IMEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  PC_sel,
   input  logic [31:0] ExtImmediate,
   input  logic [31:0] rdout1,
   input  logic        exec_ready,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] Instruction,
   output logic [31:0] PC,
   output logic [31:0] PC_plus4,
   output logic        instr_valid,
   output logic        fetch_fault
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d, instr_q, instr_d, cnt_q, cnt_d;
   logic         valid_q, valid_d, req_q, req_d, fault_q, fault_d;
   logic [31:0]  next_pc;
   logic         misaligned, advance, timeout;

   next_pc_gen u_next_pc_gen (
      .pc_i         (pc_q),
      .pc_sel_i     (PC_sel),
      .ext_imm_i    (ExtImmediate),
      .rdout1_i     (rdout1),
      .next_pc_o    (next_pc),
      .misaligned_o (misaligned)
   );

   assign advance = valid_q & exec_ready;
   // the edge that would make the count reach the limit is the faulting edge
   assign timeout = (IMEM_TIMEOUT != 0) && (cnt_q + 32'd1 == IMEM_TIMEOUT);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      req_d   = req_q;
      fault_d = fault_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            req_d   = 1'b1;
            cnt_d   = '0;
         end
         S_REQ: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               req_d   = 1'b0;
               state_d = S_HOLD;
            end else if (timeout) begin
               fault_d = 1'b1;
               req_d   = 1'b0;
               instr_d = NOP;
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_HOLD: begin
            if (advance && misaligned) begin
               fault_d = 1'b1;
               valid_d = 1'b0;
               instr_d = NOP;
               state_d = S_FAULT;
            end else if (advance) begin
               pc_d    = next_pc;
               valid_d = 1'b0;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end
         S_FAULT: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
            instr_d = NOP;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         req_q   <= req_d;
         fault_q <= fault_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign Instruction = instr_q;
   assign PC          = pc_q;
   assign PC_plus4    = pc_q + 32'd4;
   assign instr_valid = valid_q;
   assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue scoreboard for fetched instructions.
module tb_fetch_unit;
   import rv32i_pkg::*;

   logic        clk = 1'b0, reset = 1'b0;
   logic [1:0]  pc_sel = 2'b00;
   logic [31:0] imm = '0, rs1 = '0, rdata = '0;
   logic        exec_ready = 1'b0, ack = 1'b0, zero_ack = 1'b0;
   logic        imem_req, valid, fault;
   logic [31:0] imem_addr, instr, pc, pc4;
   logic        req0, valid0, fault0;
   logic [31:0] addr0, instr0, pc0, pc40;

   int total = 0, bad = 0;
   int lat = 2, wcnt = 0;
   bit mem_on = 1'b1, inject = 1'b0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0), .IMEM_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .PC_sel(pc_sel), .ExtImmediate(imm), .rdout1(rs1),
      .exec_ready(exec_ready), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(rdata), .imem_ack(ack), .Instruction(instr), .PC(pc),
      .PC_plus4(pc4), .instr_valid(valid), .fetch_fault(fault)
   );

   fetch_unit #(.RESET_PC(32'h0), .IMEM_TIMEOUT(0)) dut0 (
      .clk(clk), .reset(reset), .PC_sel(pc_sel), .ExtImmediate(imm), .rdout1(rs1),
      .exec_ready(exec_ready), .imem_req(req0), .imem_addr(addr0),
      .imem_rdata(rdata), .imem_ack(zero_ack), .Instruction(instr0), .PC(pc0),
      .PC_plus4(pc40), .instr_valid(valid0), .fetch_fault(fault0)
   );

   function automatic logic [31:0] word(input logic [31:0] a);
      return a == 32'h0 ? 32'h5531_2023 : a ^ 32'hA5A5_0013;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!valid) begin
         bad++;
         $display("FAIL wait_valid: got instr_valid=%b expected 1 within 20 cycles", valid);
      end
   endtask

   task automatic adv(input logic [1:0] sel, input logic [31:0] im, input logic [31:0] r1,
                      input logic [31:0] exp_pc, input int l);
      lat = l;
      q.push_back('{exp_pc, word(exp_pc)});
      pc_sel = sel;
      imm = im;
      rs1 = r1;
      exec_ready = 1'b1;
      @(negedge clk);
      exec_ready = 1'b0;
      chk("adv_pc", pc, exp_pc);
      chk("adv_valid_low", 32'(valid), 32'd0);
      wait_valid();
   endtask

   // memory model: acks after lat cycles of request; inject forces a stray ack
   initial begin
      forever begin
         @(negedge clk);
         if (inject) begin
            ack = 1'b1;
            rdata = 32'hDEAD_BEEF;
            wcnt = 0;
         end else if (imem_req && mem_on) begin
            if (wcnt == lat - 1) begin
               ack = 1'b1;
               rdata = word(imem_addr);
               wcnt = 0;
            end else begin
               ack = 1'b0;
               wcnt++;
            end
         end else begin
            ack = 1'b0;
            wcnt = 0;
         end
      end
   end

   initial begin
      exp_t e;
      logic pv;
      pv = 1'b0;
      forever begin
         @(negedge clk);
         if (valid && !pv) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_fetch: got pc=%h ins=%h expected none", pc, instr);
            end else begin
               e = q.pop_front();
               chk("mon_pc", pc, e.pc);
               chk("mon_ins", instr, e.ins);
            end
         end
         pv = valid;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_plus4", pc4, 32'h4);
      chk("rst_instr", instr, NOP);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      q.push_back('{32'h0, 32'h5531_2023});
      lat = 2;
      reset = 1'b1;
      @(negedge clk);
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      chk("first_valid0", 32'(valid), 32'd0);
      @(negedge clk);
      chk("first_valid1", 32'(valid), 32'd0);
      @(negedge clk);
      chk("first_valid2", 32'(valid), 32'd1);
      chk("first_req_low", 32'(imem_req), 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("stall_valid", 32'(valid), 32'd1);
         chk("stall_pc", pc, 32'h0);
         chk("stall_instr", instr, 32'h5531_2023);
      end
      adv(2'b00, 32'h0, 32'h0, 32'h4, 1);
      chk("seq_addr", imem_addr, 32'h4);
      chk("seq_plus4", pc4, 32'h8);
      adv(2'b01, 32'h0000_00FC, 32'h0, 32'h100, 3);
      adv(2'b01, 32'hFFFF_FFF0, 32'h0, 32'hF0, 1);
      adv(2'b11, 32'h4, 32'h201, 32'h204, 2);
      adv(2'b11, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1);
      chk("wrap_plus4", pc4, 32'h0);
      adv(2'b00, 32'h0, 32'h0, 32'h0, 2);
      pc_sel = 2'b10;
      imm = 32'h2;
      exec_ready = 1'b1;
      @(negedge clk);
      exec_ready = 1'b0;
      chk("mis_fault", 32'(fault), 32'd1);
      chk("mis_valid", 32'(valid), 32'd0);
      chk("mis_req", 32'(imem_req), 32'd0);
      chk("mis_pc", pc, 32'h0);
      chk("mis_instr", instr, NOP);
      repeat (5) @(negedge clk);
      chk("mis_fault_sticky", 32'(fault), 32'd1);
      chk("mis_req_sticky", 32'(imem_req), 32'd0);
      chk("mis_pc_sticky", pc, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst2_fault", 32'(fault), 32'd0);
      mem_on = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      repeat (15) @(negedge clk);
      chk("to_fault_15", 32'(fault), 32'd0);
      chk("to_req_15", 32'(imem_req), 32'd1);
      @(negedge clk);
      chk("to_fault_16", 32'(fault), 32'd1);
      chk("to_req_16", 32'(imem_req), 32'd0);
      chk("to_valid_16", 32'(valid), 32'd0);
      repeat (100) @(negedge clk);
      chk("nto_fault", 32'(fault0), 32'd0);
      chk("nto_req", 32'(req0), 32'd1);
      chk("nto_valid", 32'(valid0), 32'd0);
      chk("nto_addr", addr0, 32'h0);
      chk("nto_pc", pc0, 32'h0);
      chk("nto_plus4", pc40, 32'h4);
      chk("nto_instr", instr0, NOP);
      reset = 1'b0;
      @(negedge clk);
      mem_on = 1'b1;
      lat = 3;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      chk("mid_in_req", 32'(imem_req), 32'd1);
      reset = 1'b0;
      inject = 1'b1;
      #1;
      chk("mid_rst_req", 32'(imem_req), 32'd0);
      chk("mid_rst_valid", 32'(valid), 32'd0);
      chk("mid_rst_pc", pc, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("late_ack_valid", 32'(valid), 32'd0);
      chk("late_ack_instr", instr, NOP);
      q.push_back('{32'h0, 32'h5531_2023});
      lat = 1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      inject = 1'b0;
      @(negedge clk);
      chk("restart_valid", 32'(valid), 32'd0);
      chk("restart_req", 32'(imem_req), 32'd1);
      chk("restart_addr", imem_addr, 32'h0);
      wait_valid();
      @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the RV32I single-cycle core. It sits directly upstream of Decode_Unit: it owns the PC register, fetches from instruction memory over a req/ack handshake, and presents a held Instruction to decode. It consumes Decode_Unit's PC_sel, ExtImmediate and rdout1 to form the next PC when the core retires the current instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
IMEM_TIMEOUT, 16, max cycles in REQ without ack before fault; 0 disables the timeout.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
PC_sel  input  2  next-PC select from Decode_Unit: 00 PC+4, 01 branch taken PC+imm, 10 jal PC+imm, 11 jalr (rdout1+imm)&~1
ExtImmediate  input  32  sign-extended immediate from Decode_Unit
rdout1  input  32  rs1 value from Decode_Unit (jalr base)
exec_ready  input  1  core finished current instruction (data memory not stalling)
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, equals PC
imem_rdata  input  32  instruction word, valid when imem_ack=1
imem_ack  input  1  memory response strobe
Instruction  output  32  held instruction to Decode_Unit
PC  output  32  address of Instruction
PC_plus4  output  32  PC+4 (link value for writeback)
instr_valid  output  1  Instruction is valid for decode/execute
fetch_fault  output  1  sticky fault flag (misaligned target or timeout)

Behaviour:
- Reset (async, reset=0): PC=RESET_PC, Instruction=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, fetch_fault=0, wait counter=0, state=IDLE.
- States: IDLE, REQ, HOLD, FAULT. All registered; outputs are registered except imem_addr=PC and PC_plus4=PC+4.
- IDLE: one cycle after reset release -> REQ.
- REQ: imem_req=1, imem_addr stable. imem_ack sampled only while imem_req=1. On ack at an edge: Instruction<=imem_rdata, instr_valid<=1, imem_req<=0 -> HOLD. An ack in the first REQ cycle is legal, and the instruction is valid on the next cycle. Minimum fetch latency is 1 cycle; steady-state throughput is 1 instruction per 2 cycles.
- Timeout: the counter increments each REQ cycle without ack. When the counter reaches IMEM_TIMEOUT (and the parameter is nonzero): fetch_fault<=1, imem_req<=0 -> FAULT. The counter clears on entering REQ.
- HOLD: Instruction, PC and instr_valid are held while exec_ready=0. advance = instr_valid & exec_ready. On advance: PC<=next_pc, instr_valid<=0 -> REQ.
- next_pc arithmetic: all modulo 2^32. PC+4 at 32'hFFFF_FFFC wraps to 0. jalr clears bit 0 after the add.
- Misaligned target: if next_pc[1]=1 on advance, PC is not updated, fetch_fault<=1, instr_valid<=0 -> FAULT.
- FAULT: terminal. imem_req=0, instr_valid=0, Instruction=NOP. Only reset exits.
- Ignored inputs: imem_ack outside REQ (including a late ack after a mid-fetch reset); PC_sel, ExtImmediate and rdout1 when advance=0.
- Reset mid-fetch: returns immediately to reset values and restarts from RESET_PC.

Decomposition:
- rv32i_pkg holds:
  - PC_sel encodings (PCSEL_PLUS4, PCSEL_BRANCH, PCSEL_JAL, PCSEL_JALR)
  - NOP constant 32'h0000_0013
  - fetch state enum
- One combinational sub-module, next_pc_gen: inputs PC, PC_sel, ExtImmediate, rdout1; outputs next_pc and misaligned.

Test Plan:
- Reset and first fetch: reset=0 for 2 cycles, then release; memory returns 32'h55312023 with 2-cycle ack latency -> imem_req rises on cycle 2 after release with imem_addr=0. Two cycles later, instr_valid=1, Instruction=32'h55312023, PC=0.
- Sequential stall: exec_ready=0 for 3 cycles -> outputs held. exec_ready=1 with PC_sel=00 -> next imem_addr=4, PC_plus4=8 after advance.
- Branch/jal/jalr: from PC=0x100 with imm=0xFFFFFFF0 and PC_sel=01 -> PC=0xF0. With PC_sel=11, rdout1=0x201, imm=4 -> PC=0x204 (bit 0 cleared).
- Misaligned and wrap-around:
  - PC_sel=10 with imm=2 -> fetch_fault=1, imem_req stays 0, PC unchanged until reset.
  - PC=0xFFFFFFFC with PC_sel=00 -> PC=0.
- Timeout: no ack for 16 REQ cycles -> fetch_fault=1 on the 16th edge. With IMEM_TIMEOUT=0, no fault after 100 cycles.
- Reset mid-fetch: assert reset while in REQ; a late ack arrives during/after reset -> ignored, instr_valid=0, and fetch restarts at RESET_PC.
